frame_collector: RTL and testbench
==================================

FRAME_COLLECTOR -- requirements
Module: frame_collector

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set max payload bits per frame and width of outData.
REQ-002 Parameter LEN_W, default 5, SHALL set width of outLen; LEN_W SHALL be ≥ clog2(DATA_W+1).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low; asserted when 0.
REQ-005 clkEn  in  1  bit-rate enable; serial-side sampling occurs only in cycles with clkEn=1 (qualified cycles).
REQ-006 serOut  in  1  serial payload bit from upstream serial controller.
REQ-007 serOutValid  in  1  serOut carries a payload bit this qualified cycle.
REQ-008 portNum  in  2  destination port of the frame, stable while serOutValid=1.
REQ-009 outValid  out  1  output slot holds a completed frame.
REQ-010 outReady  in  1  consumer accepts slot when outValid=1 (ungated by clkEn).
REQ-011 outPort  out  2  port of the held frame.
REQ-012 outData  out  DATA_W  payload, right-justified, last-received bit at bit 0, unused upper bits 0.
REQ-013 outLen  out  LEN_W  payload bit count of held frame, 0..DATA_W.
REQ-014 dropped  out  1  one-cycle pulse when a completed frame is discarded.
REQ-015 busy  out  1  high while in COLLECT.

Function
REQ-016 Frame SHALL be a run of consecutive qualified cycles with serOutValid=1, terminated by first qualified cycle with serOutValid=0.
REQ-017 FSM SHALL have states IDLE and COLLECT; IDLE->COLLECT on qualified serOutValid=1; COLLECT->IDLE on qualified serOutValid=0; non-qualified cycles hold state.
REQ-018 On IDLE->COLLECT, assembly register SHALL clear, capture portNum, load first bit, and set bit count to 1.
REQ-019 Each qualified COLLECT cycle with serOutValid=1 SHALL shift serOut into bit 0 (left shift) and increment count.
REQ-020 Bits beyond DATA_W SHALL shift out of the MSB and be lost; count SHALL saturate at DATA_W.
REQ-021 On frame end (cycle t), if slot empty or outReady=1 at t, frame SHALL be loaded; outValid=1 from t+1 with outPort/outData/outLen of that frame.
REQ-022 On frame end with outValid=1 and outReady=0, frame SHALL be discarded, slot unchanged, dropped=1 at t+1 only.
REQ-023 Handshake: slot SHALL clear on any cycle with outValid=1 and outReady=1 unless REQ-021 reloads it same cycle; outputs SHALL remain stable while outValid=1 and outReady=0.
REQ-024 A new frame SHALL be collectable immediately after termination cycle (back-to-back, one-cycle gap).
REQ-025 busy SHALL equal (state==COLLECT), registered, no combinational path from inputs.

Reset
REQ-026 While rst=0: state=IDLE, outValid=0, outPort=0, outData=0, outLen=0, dropped=0, busy=0, assembly register and count=0.
REQ-027 Reset mid-frame SHALL discard partial frame; after release, next serOutValid=1 starts a fresh frame.

Configuration
REQ-028 With FRAME_COLLECTOR_PARITY_EN defined, output port outParity (1 bit) SHALL hold XOR of all received payload bits of the held frame (including bits lost per REQ-020), reset 0, valid with outValid.
REQ-029 Without FRAME_COLLECTOR_PARITY_EN, outParity and its logic SHALL be absent.

Structure
REQ-030 Shared package SHALL hold the FSM state encoding (IDLE=0, COLLECT=1) and default DATA_W/LEN_W constants.
REQ-031 Output slot with handshake SHALL be a sub-module frame_slot (load, ready/valid, hold); FSM and assembly stay in top.

Verification
REQ-032 clkEn=1, port=2, bits 1,0,1,1 then valid=0, outReady=0 -> outValid=1, outPort=2, outData=0x000B, outLen=4.
REQ-033 Slot full (outReady=0), second 3-bit frame completes -> dropped pulse 1 cycle, slot still 0x000B/len 4.
REQ-034 clkEn pulsed every 4th cycle, frame 1,1,0 -> same result as contiguous clkEn (0x0006, len 3); non-qualified cycles change nothing.
REQ-035 20 ones with DATA_W=16 -> outData=0xFFFF, outLen=16; parity build -> outParity=0.
REQ-036 rst=0 after 5 bits, release, send 2-bit frame 1,0 -> outData=0x0002, outLen=2, no trace of prior bits.
REQ-037 Frame end in same cycle as outValid&outReady=1 -> new frame loaded, outValid stays 1, dropped stays 0.

Source files
------------

// File: rtl/frame_collector_pkg.sv
//------------------------------------------------------------------------------
// Module  : frame_collector_pkg
// Brief   : Shared constants and FSM state encoding for the frame collector.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package frame_collector_pkg;

    localparam int unsigned c_DATA_W_DEFAULT = 16;
    localparam int unsigned c_LEN_W_DEFAULT  = 5;

    typedef logic [0:0] fc_state_t;

    localparam fc_state_t c_ST_IDLE    = 1'b0;
    localparam fc_state_t c_ST_COLLECT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/frame_slot.sv
//------------------------------------------------------------------------------
// Module  : frame_slot
// Brief   : Single-entry output slot with ready/valid handshake and drop pulse.
//           Optional parity field when FRAME_COLLECTOR_PARITY_EN is defined.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module frame_slot #(
    parameter int DATA_W = 16,
    parameter int LEN_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [1:0]        i_port,
    input  logic [DATA_W-1:0] i_data,
    input  logic [LEN_W-1:0]  i_len,
`ifdef FRAME_COLLECTOR_PARITY_EN
    input  logic              i_parity,
    output logic              o_parity,
`endif
    input  logic              i_ready,
    output logic              o_valid,
    output logic [1:0]        o_port,
    output logic [DATA_W-1:0] o_data,
    output logic [LEN_W-1:0]  o_len,
    output logic              o_dropped
);

    logic w_accept;
    logic w_drop;

    // A completing frame wins over the handshake clear in the same cycle.
    assign w_accept = i_load & (~o_valid | i_ready);
    assign w_drop   = i_load & o_valid & ~i_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_valid   <= 1'b0;
            o_port    <= '0;
            o_data    <= '0;
            o_len     <= '0;
            o_dropped <= 1'b0;
        end else begin
            o_dropped <= w_drop;
            if (w_accept) begin
                o_valid <= 1'b1;
                o_port  <= i_port;
                o_data  <= i_data;
                o_len   <= i_len;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

`ifdef FRAME_COLLECTOR_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_parity <= 1'b0;
        end else if (w_accept) begin
            o_parity <= i_parity;
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/frame_collector.sv
//------------------------------------------------------------------------------
// Module  : frame_collector
// Brief   : Assembles serial payload bits into frames and hands them to a
//           ready/valid output slot. Optional outParity via
//           FRAME_COLLECTOR_PARITY_EN.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module frame_collector
    import frame_collector_pkg::*;
#(
    parameter int DATA_W = c_DATA_W_DEFAULT,
    parameter int LEN_W  = c_LEN_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clkEn,
    input  logic              serOut,
    input  logic              serOutValid,
    input  logic [1:0]        portNum,
    output logic              outValid,
    input  logic              outReady,
    output logic [1:0]        outPort,
    output logic [DATA_W-1:0] outData,
    output logic [LEN_W-1:0]  outLen,
    output logic              dropped,
`ifdef FRAME_COLLECTOR_PARITY_EN
    output logic              outParity,
`endif
    output logic              busy
);

    fc_state_t         r_state;
    fc_state_t         w_state_nxt;
    logic [DATA_W-1:0] r_asm;
    logic [DATA_W-1:0] w_asm_shift;
    logic [LEN_W-1:0]  r_cnt;
    logic [1:0]        r_port;
    logic              w_start;
    logic              w_shift;
    logic              w_frame_end;

    localparam logic [LEN_W-1:0] c_CNT_MAX = LEN_W'(DATA_W);

    assign w_start     = clkEn & serOutValid  & (r_state == c_ST_IDLE);
    assign w_shift     = clkEn & serOutValid  & (r_state == c_ST_COLLECT);
    assign w_frame_end = clkEn & ~serOutValid & (r_state == c_ST_COLLECT);

    generate
        if (DATA_W > 1) begin : g_shift_wide
            assign w_asm_shift = {r_asm[DATA_W-2:0], serOut};
        end else begin : g_shift_narrow
            assign w_asm_shift = serOut;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:    if (clkEn && serOutValid)  w_state_nxt = c_ST_COLLECT;
            c_ST_COLLECT: if (clkEn && !serOutValid) w_state_nxt = c_ST_IDLE;
            default:      w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == c_ST_COLLECT);
    end

    // Bits past DATA_W fall off the MSB; the count pins at DATA_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_asm  <= '0;
            r_cnt  <= '0;
            r_port <= '0;
        end else if (w_start) begin
            r_asm  <= {{(DATA_W-1){1'b0}}, serOut};
            r_cnt  <= LEN_W'(1);
            r_port <= portNum;
        end else if (w_shift) begin
            r_asm <= w_asm_shift;
            if (r_cnt != c_CNT_MAX) begin
                r_cnt <= r_cnt + LEN_W'(1);
            end
        end
    end

`ifdef FRAME_COLLECTOR_PARITY_EN
    logic r_par;

    // Parity covers every received bit, including those shifted out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par <= 1'b0;
        end else if (w_start) begin
            r_par <= serOut;
        end else if (w_shift) begin
            r_par <= r_par ^ serOut;
        end
    end
`endif

    frame_slot #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_frame_end),
        .i_port    (r_port),
        .i_data    (r_asm),
        .i_len     (r_cnt),
`ifdef FRAME_COLLECTOR_PARITY_EN
        .i_parity  (r_par),
        .o_parity  (outParity),
`endif
        .i_ready   (outReady),
        .o_valid   (outValid),
        .o_port    (outPort),
        .o_data    (outData),
        .o_len     (outLen),
        .o_dropped (dropped)
    );

endmodule

`default_nettype wire

// File: tb/tb_frame_collector.sv
//------------------------------------------------------------------------------
// Module  : tb_frame_collector
// Brief   : Directed and randomized bench for frame_collector with a
//           queue-based frame reference model.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_frame_collector;

    localparam int DATA_W = 16;
    localparam int LEN_W  = 5;

    logic              clk;
    logic              rst;
    logic              clkEn;
    logic              serOut;
    logic              serOutValid;
    logic [1:0]        portNum;
    logic              outValid;
    logic              outReady;
    logic [1:0]        outPort;
    logic [DATA_W-1:0] outData;
    logic [LEN_W-1:0]  outLen;
    logic              dropped;
    logic              busy;
`ifdef FRAME_COLLECTOR_PARITY_EN
    logic              outParity;
`endif

    frame_collector #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clkEn       (clkEn),
        .serOut      (serOut),
        .serOutValid (serOutValid),
        .portNum     (portNum),
        .outValid    (outValid),
        .outReady    (outReady),
        .outPort     (outPort),
        .outData     (outData),
        .outLen      (outLen),
        .dropped     (dropped),
`ifdef FRAME_COLLECTOR_PARITY_EN
        .outParity   (outParity),
`endif
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a frame is the list of bits received so far.
    int m_q[$];
    bit m_in_frame;
    int m_fport;
    bit m_valid;
    int m_port, m_data, m_len, m_par;
    bit m_drop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int frame_value();
        int v = 0;
        foreach (m_q[i]) v = (v * 2 + m_q[i]) % (1 << DATA_W);
        return v;
    endfunction

    function automatic int frame_parity();
        int p = 0;
        foreach (m_q[i]) p ^= m_q[i];
        return p;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_in_frame = 0;
        m_fport = 0;
        m_valid = 0;
        m_port = 0; m_data = 0; m_len = 0; m_par = 0;
        m_drop = 0;
    endtask

    task automatic model_step(input bit en, input bit v, input bit b, input int p, input bit rdy);
        bit ended = 0;
        if (en) begin
            if (v) begin
                if (!m_in_frame) begin
                    m_q.delete();
                    m_fport = p;
                    m_in_frame = 1;
                end
                m_q.push_back(b);
            end else if (m_in_frame) begin
                ended = 1;
                m_in_frame = 0;
            end
        end
        m_drop = 0;
        if (ended && (!m_valid || rdy)) begin
            m_valid = 1;
            m_port  = m_fport;
            m_data  = frame_value();
            m_len   = (m_q.size() > DATA_W) ? DATA_W : m_q.size();
            m_par   = frame_parity();
        end else if (ended) begin
            m_drop = 1;
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
    endtask

    task automatic compare_all();
        check("valid", outValid, m_valid);
        check("busy", busy, m_in_frame);
        check("dropped", dropped, m_drop);
        if (m_valid) begin
            check("port", outPort, m_port);
            check("data", outData, m_data);
            check("len", outLen, m_len);
`ifdef FRAME_COLLECTOR_PARITY_EN
            check("parity", outParity, m_par);
`endif
        end
    endtask

    // Called at a negedge: apply inputs, advance one clock, compare.
    task automatic cyc(input bit en, input bit v, input bit b, input int p, input bit rdy);
        clkEn = en; serOutValid = v; serOut = b; portNum = 2'(p); outReady = rdy;
        model_step(en, v, b, p, rdy);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clkEn = 0; serOutValid = 0; serOut = 0; outReady = 0;
        model_reset();
        #1;
        check("rst_valid", outValid, 0);
        check("rst_busy", busy, 0);
        check("rst_data", outData, 0);
        check("rst_len", outLen, 0);
        check("rst_port", outPort, 0);
        check("rst_dropped", dropped, 0);
`ifdef FRAME_COLLECTOR_PARITY_EN
        check("rst_parity", outParity, 0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic send(input int nbits, input int pattern, input int p, input bit rdy);
        for (int i = nbits - 1; i >= 0; i--) cyc(1, 1, pattern[i], p, rdy);
    endtask

    initial begin
        bit last_v;
        int rp;
        rst = 1'b0;
        clkEn = 0; serOutValid = 0; serOut = 0; portNum = 0; outReady = 0;
        @(negedge clk);
        do_reset();

        // Basic 4-bit frame to port 2
        send(4, 'b1011, 2, 0);
        cyc(1, 0, 0, 2, 0);
        check("t1_valid", outValid, 1);
        check("t1_port", outPort, 2);
        check("t1_data", outData, 16'h000B);
        check("t1_len", outLen, 4);

        // Slot full: second frame is dropped
        send(3, 'b101, 1, 0);
        cyc(1, 0, 0, 1, 0);
        check("t2_dropped", dropped, 1);
        check("t2_data", outData, 16'h000B);
        check("t2_len", outLen, 4);
        cyc(0, 0, 0, 1, 0);
        check("t2_drop_once", dropped, 0);
        cyc(0, 0, 0, 1, 1);
        check("t2_drain", outValid, 0);

        // Sparse clkEn: frame 1,1,0
        for (int i = 2; i >= 0; i--) begin
            cyc(1, 1, 3'b110 >> i, 1, 0);
            repeat (3) cyc(0, 1'($urandom), 1'($urandom), 1, 0);
        end
        cyc(1, 0, 0, 1, 0);
        check("t3_data", outData, 16'h0006);
        check("t3_len", outLen, 3);
        check("t3_port", outPort, 1);
        cyc(0, 0, 0, 1, 1);

        // Overlong frame saturates
        for (int i = 0; i < 20; i++) cyc(1, 1, 1, 3, 0);
        cyc(1, 0, 0, 3, 0);
        check("t4_data", outData, 16'hFFFF);
        check("t4_len", outLen, 16);
`ifdef FRAME_COLLECTOR_PARITY_EN
        check("t4_parity", outParity, 0);
`endif
        cyc(0, 0, 0, 3, 1);

        // Reset mid-frame
        send(5, 'b11111, 0, 0);
        do_reset();
        send(2, 'b10, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check("t5_data", outData, 16'h0002);
        check("t5_len", outLen, 2);

        // Frame end coincides with a handshake
        send(2, 'b11, 2, 0);
        cyc(1, 0, 0, 2, 1);
        check("t6_valid", outValid, 1);
        check("t6_dropped", dropped, 0);
        check("t6_data", outData, 16'h0003);
        check("t6_len", outLen, 2);
        cyc(0, 0, 0, 2, 1);

        // Randomized traffic
        last_v = 0;
        rp = 0;
        for (int n = 0; n < 4000; n++) begin
            bit en, v, b, rdy;
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
                last_v = 0;
            end
            en  = ($urandom_range(0, 3) != 0);
            v   = ($urandom_range(0, 4) != 0);
            b   = 1'($urandom);
            rdy = 1'($urandom);
            if (!last_v) rp = $urandom_range(0, 3);
            cyc(en, v, b, rp, rdy);
            last_v = v;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
